// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit pipelined core: opcodes, instruction field slots, default widths.
// Optional feature macro used by id_stage: ID_STALL_CNT_EN.
package core_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int REG_AW_DEF = 4;
  localparam int OPC_W      = 4;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_LI  = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
  localparam logic [OPC_W-1:0] OP_AND = 4'h4;
  localparam logic [OPC_W-1:0] OP_OR  = 4'h5;
  localparam logic [OPC_W-1:0] OP_XOR = 4'h6;
  localparam logic [OPC_W-1:0] OP_MOV = 4'h7;

  // Register fields sit at slot*REG_AW; the opcode occupies the top OPC_W bits.
  localparam int RD_SLOT  = 2;
  localparam int RS1_SLOT = 1;
  localparam int RS2_SLOT = 0;

  typedef enum logic {ST_EMPTY, ST_FULL} id_state_e;

  function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_MOV);
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage bus: fetch handshake, execute issue, writeback and register-file control pins.
interface id_stage_if import core_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
);
  localparam int INSTR_W = OPC_W + 3 * REG_AW;

  logic               flush;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               instr_ready;
  logic               ex_ready;
  logic               ex_valid;
  logic [OPC_W-1:0]   ex_op;
  logic [REG_AW-1:0]  ex_rd;
  logic               wb_valid;
  logic [REG_AW-1:0]  wb_rd;
  logic [DATA_W-1:0]  wb_data;
  logic [REG_AW-1:0]  rf_rs1;
  logic [REG_AW-1:0]  rf_rs2;
  logic [REG_AW-1:0]  rf_rd;
  logic [DATA_W-1:0]  rf_imm;
  logic               rf_w;
  logic               illegal;

  modport master (
    output flush, instr_valid, instr, ex_ready, wb_valid, wb_rd, wb_data,
    input  instr_ready, ex_valid, ex_op, ex_rd, rf_rs1, rf_rs2, rf_rd, rf_imm, rf_w, illegal
  );

  modport slave (
    input  flush, instr_valid, instr, ex_ready, wb_valid, wb_rd, wb_data,
    output instr_ready, ex_valid, ex_op, ex_rd, rf_rs1, rf_rs2, rf_rd, rf_imm, rf_w, illegal
  );
endinterface

// File: rtl/id_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback, set wins.
module id_scoreboard #(
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic [REG_AW-1:0] look_a,
  input  logic [REG_AW-1:0] look_b,
  input  logic [REG_AW-1:0] look_c,
  output logic              hit_a,
  output logic              hit_b,
  output logic              hit_c
);
  localparam int NREGS = 2 ** REG_AW;

  logic [NREGS-1:0] pending_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_pend
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pending_reg[gi] <= 1'b0;
        end else if (set_en && (set_addr == REG_AW'(gi))) begin
          pending_reg[gi] <= 1'b1;
        end else if (clr_en && (clr_addr == REG_AW'(gi))) begin
          pending_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign hit_a = pending_reg[look_a];
  assign hit_b = pending_reg[look_b];
  assign hit_c = pending_reg[look_c];
endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: holds one instruction, issues ALU ops, executes LI via the RF port.
// Optional stall cycle counter enabled by ID_STALL_CNT_EN.
module id_stage import core_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic        clk,
  input  logic        rst,
  id_stage_if.slave   bus
`ifdef ID_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);
  localparam int INSTR_W = OPC_W + 3 * REG_AW;

  id_state_e          state_reg;
  logic [INSTR_W-1:0] instr_reg;
  logic               illegal_reg;

  logic [OPC_W-1:0]  op;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic [DATA_W-1:0] imm;
  logic full, pend_rs1, pend_rs2, pend_rd;
  logic alu_go, li_go, pass_go, retire, ready, accept, wb_take;

  assign op   = instr_reg[INSTR_W-1 -: OPC_W];
  assign rd   = instr_reg[RD_SLOT*REG_AW +: REG_AW];
  assign rs1  = instr_reg[RS1_SLOT*REG_AW +: REG_AW];
  assign rs2  = instr_reg[RS2_SLOT*REG_AW +: REG_AW];
  assign imm  = instr_reg[DATA_W-1:0];
  assign full = (state_reg == ST_FULL);

  id_scoreboard #(.REG_AW(REG_AW)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (alu_go),
    .set_addr (rd),
    .clr_en   (wb_take),
    .clr_addr (bus.wb_rd),
    .look_a   (rs1),
    .look_b   (rs2),
    .look_c   (rd),
    .hit_a    (pend_rs1),
    .hit_b    (pend_rs2),
    .hit_c    (pend_rd)
  );

  // A flushed instruction never retires, so all retire terms are gated by flush.
  assign alu_go  = full && !bus.flush && is_alu_op(op) && bus.ex_ready
                   && !pend_rs1 && !pend_rs2 && !pend_rd;
  assign li_go   = full && !bus.flush && (op == OP_LI) && !pend_rd && !bus.wb_valid;
  assign pass_go = full && !bus.flush && ((op == OP_NOP) || op[OPC_W-1]);
  assign retire  = alu_go || li_go || pass_go;
  assign ready   = rst && !bus.flush && (!full || retire);
  assign accept  = bus.instr_valid && ready;
  assign wb_take = rst && bus.wb_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_EMPTY;
      instr_reg   <= '0;
      illegal_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            state_reg <= ST_FULL;
            instr_reg <= bus.instr;
          end
        end
        ST_FULL: begin
          if (bus.flush) begin
            state_reg <= ST_EMPTY;
          end else if (accept) begin
            instr_reg <= bus.instr;
          end else if (retire) begin
            state_reg <= ST_EMPTY;
          end
        end
        default: state_reg <= ST_EMPTY;
      endcase
      if (pass_go && op[OPC_W-1]) begin
        illegal_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.ex_valid = 1'b0;
    bus.ex_op    = '0;
    bus.ex_rd    = '0;
    bus.rf_w     = 1'b0;
    bus.rf_rd    = '0;
    bus.rf_imm   = '0;
    if (alu_go) begin
      bus.ex_valid = 1'b1;
      bus.ex_op    = op;
      bus.ex_rd    = rd;
    end
    // Writeback owns the write port; a held LI waits for a free cycle.
    if (wb_take) begin
      bus.rf_w   = 1'b1;
      bus.rf_rd  = bus.wb_rd;
      bus.rf_imm = bus.wb_data;
    end else if (li_go) begin
      bus.rf_w   = 1'b1;
      bus.rf_rd  = rd;
      bus.rf_imm = imm;
    end
  end

  assign bus.instr_ready = ready;
  assign bus.rf_rs1      = rs1;
  assign bus.rf_rs2      = rs2;
  assign bus.illegal     = illegal_reg;

`ifdef ID_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
    end else if (full && !retire && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed vectors push expected ex/rf events, a monitor pops and compares.
module tb_id_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_if #(.DATA_W(8), .REG_AW(4)) bus ();

`ifdef ID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  id_stage #(.DATA_W(8), .REG_AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ID_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    logic [3:0] a;
    logic [7:0] b;
  } exp_t;

  exp_t ex_q[$];
  exp_t rf_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_ex_cyc = -1;
  int last_rf_cyc = -1;
  int rf_cnt = 0;
  int mark_cyc;
  int base;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ex(input logic [3:0] op, input logic [3:0] rd);
    exp_t e;
    e.a = rd;
    e.b = {4'h0, op};
    ex_q.push_back(e);
  endtask

  task automatic push_rf(input logic [3:0] rd, input logic [7:0] d);
    exp_t e;
    e.a = rd;
    e.b = d;
    rf_q.push_back(e);
  endtask

  // Monitor: every issued op or register-file write must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (bus.ex_valid === 1'b1) begin
      last_ex_cyc = cyc;
      if (ex_q.size() == 0) begin
        chk("ex_unexpected", {24'h0, bus.ex_op, bus.ex_rd}, 32'hFFFF);
      end else begin
        e = ex_q.pop_front();
        $display("ex  op=%0h rd=%0h (exp op=%0h rd=%0h) cyc=%0d", bus.ex_op, bus.ex_rd, e.b[3:0], e.a, cyc);
        chk("ex_op", {28'h0, bus.ex_op}, {28'h0, e.b[3:0]});
        chk("ex_rd", {28'h0, bus.ex_rd}, {28'h0, e.a});
      end
    end
    if (bus.rf_w === 1'b1) begin
      last_rf_cyc = cyc;
      rf_cnt++;
      if (rf_q.size() == 0) begin
        chk("rf_unexpected", {20'h0, bus.rf_rd, bus.rf_imm}, 32'hFFFF);
      end else begin
        e = rf_q.pop_front();
        $display("rf  rd=%0h data=%0h (exp rd=%0h data=%0h) cyc=%0d", bus.rf_rd, bus.rf_imm, e.a, e.b, cyc);
        chk("rf_rd", {28'h0, bus.rf_rd}, {28'h0, e.a});
        chk("rf_imm", {24'h0, bus.rf_imm}, {24'h0, e.b});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    bus.flush = 0; bus.instr_valid = 0; bus.instr = '0; bus.ex_ready = 1;
    bus.wb_valid = 0; bus.wb_rd = '0; bus.wb_data = '0;
    rst = 1;
    #2 rst = 0;
    mid();
    chk("reset_ready", {31'h0, bus.instr_ready}, 0);
    chk("reset_ex_valid", {31'h0, bus.ex_valid}, 0);
    chk("reset_rf_w", {31'h0, bus.rf_w}, 0);
    chk("reset_illegal", {31'h0, bus.illegal}, 0);
    step(); rst = 1; mid();
    chk("release_ready", {31'h0, bus.instr_ready}, 1);

    // Back-to-back LI r1,0x11 / LI r2,0x22
    step(); bus.instr_valid = 1; bus.instr = 16'h1111; mid();
    chk("b2b_ready0", {31'h0, bus.instr_ready}, 1);
    base = rf_cnt;
    step(); bus.instr = 16'h1222; push_rf(4'h1, 8'h11); mid();
    chk("b2b_ready1", {31'h0, bus.instr_ready}, 1);
    step(); bus.instr_valid = 0; push_rf(4'h2, 8'h22); mid();
    chk("b2b_ready2", {31'h0, bus.instr_ready}, 1);
    chk("b2b_two_writes", rf_cnt - base, 2);

    // RAW: ADD r4,r1,r2 then SUB r5,r4,r1
    step(); bus.instr_valid = 1; bus.instr = 16'h2412; mid();
    step(); bus.instr = 16'h3541; push_ex(4'h2, 4'h4); mid();
    chk("raw_accept_sub", {31'h0, bus.instr_ready}, 1);
    step(); bus.instr_valid = 0; mid();
    chk("raw_stall_ex", {31'h0, bus.ex_valid}, 0);
    chk("raw_stall_ready", {31'h0, bus.instr_ready}, 0);
    step(); mid();
    chk("raw_stall_ex2", {31'h0, bus.ex_valid}, 0);
    step(); bus.wb_valid = 1; bus.wb_rd = 4'h4; bus.wb_data = 8'h33; push_rf(4'h4, 8'h33); mid();
    chk("raw_no_bypass", {31'h0, bus.ex_valid}, 0);
    mark_cyc = cyc;
    step(); bus.wb_valid = 0; push_ex(4'h3, 4'h5); mid();
    chk("raw_release_cycle", last_ex_cyc, mark_cyc + 1);

    // Port conflict: LI r6,0x7F against writeback r2=0x33
    step(); bus.instr_valid = 1; bus.instr = 16'h167F; mid();
    step(); bus.instr_valid = 0; bus.wb_valid = 1; bus.wb_rd = 4'h2; bus.wb_data = 8'h33;
    push_rf(4'h2, 8'h33); mid();
    chk("conflict_li_stall", {31'h0, bus.instr_ready}, 0);
    mark_cyc = cyc;
    step(); bus.wb_valid = 0; push_rf(4'h6, 8'h7F); mid();
    chk("conflict_li_next", last_rf_cyc, mark_cyc + 1);

    // Set/clear collision on r4, then AND r7,r4,r1 must stall
    step(); bus.instr_valid = 1; bus.instr = 16'h2412; mid();
    step(); bus.instr = 16'h4741; bus.wb_valid = 1; bus.wb_rd = 4'h4; bus.wb_data = 8'h44;
    push_ex(4'h2, 4'h4); push_rf(4'h4, 8'h44); mid();
    chk("coll_accept", {31'h0, bus.instr_ready}, 1);
    step(); bus.instr_valid = 0; bus.wb_valid = 0; mid();
    chk("coll_stall_ex", {31'h0, bus.ex_valid}, 0);
    chk("coll_stall_ready", {31'h0, bus.instr_ready}, 0);
    step(); mid();
    chk("coll_stall_ex2", {31'h0, bus.ex_valid}, 0);
    step(); bus.wb_valid = 1; bus.wb_rd = 4'h4; bus.wb_data = 8'h55; push_rf(4'h4, 8'h55); mid();
    mark_cyc = cyc;
    step(); bus.wb_valid = 0; push_ex(4'h4, 4'h7); mid();
    chk("coll_release_cycle", last_ex_cyc, mark_cyc + 1);

    // Illegal opcode 0xA
    step(); bus.instr_valid = 1; bus.instr = 16'hA000; mid();
    chk("illegal_before", {31'h0, bus.illegal}, 0);
    step(); bus.instr_valid = 0; mid();
    chk("illegal_retire", {31'h0, bus.instr_ready}, 1);
    step(); mid();
    chk("illegal_set", {31'h0, bus.illegal}, 1);
    chk("illegal_empty_ready", {31'h0, bus.instr_ready}, 1);

    // Flush drops a held ADD r8,r1,r2
    step(); bus.instr_valid = 1; bus.instr = 16'h2812; mid();
    step(); bus.flush = 1; bus.instr = 16'h2912; mid();
    chk("flush_ready", {31'h0, bus.instr_ready}, 0);
    chk("flush_no_issue", {31'h0, bus.ex_valid}, 0);
    step(); bus.flush = 0; bus.instr_valid = 0; mid();
    chk("flush_emptied", {31'h0, bus.instr_ready}, 1);
    chk("flush_no_issue2", {31'h0, bus.ex_valid}, 0);
    step(); mid();

    // Reset mid-stall: ADD r3 makes r3 pending, LI r3,0x5A stalls behind it
    step(); bus.instr_valid = 1; bus.instr = 16'h2312; mid();
    step(); bus.instr = 16'h135A; push_ex(4'h2, 4'h3); mid();
    chk("rst_accept_li", {31'h0, bus.instr_ready}, 1);
    step(); bus.instr_valid = 0; mid();
    chk("rst_li_stalled", {31'h0, bus.instr_ready}, 0);
    step(); rst = 0; bus.wb_valid = 1; bus.wb_rd = 4'h9; bus.wb_data = 8'h99; mid();
    chk("rst_mid_rf_w", {31'h0, bus.rf_w}, 0);
    chk("rst_mid_ex_valid", {31'h0, bus.ex_valid}, 0);
    chk("rst_mid_ready", {31'h0, bus.instr_ready}, 0);
    chk("rst_mid_illegal", {31'h0, bus.illegal}, 0);
    step(); rst = 1; bus.wb_valid = 0; mid();
    chk("rst_after_ready", {31'h0, bus.instr_ready}, 1);
    chk("rst_after_illegal", {31'h0, bus.illegal}, 0);
    step(); bus.instr_valid = 1; bus.instr = 16'h135A; mid();
    step(); bus.instr_valid = 0; push_rf(4'h3, 8'h5A); mid();
    chk("rst_pending_cleared", {31'h0, bus.instr_ready}, 1);
    step(); mid();
    step(); mid();

    chk("ex_queue_drained", ex_q.size(), 0);
    chk("rf_queue_drained", rf_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
